// File: rtl/platform_scroller_pkg.sv
// Shared types and constants for the platform scroller: FSM states, platform
// record layout and the coordinate helpers used by the load and respawn paths.
package platform_scroller_pkg;

   localparam int unsigned NUM_PLAT     = 16;
   localparam int unsigned IDX_W        = 4;
   localparam int unsigned COORD_W      = 9;
   localparam int unsigned MOT_W        = 10;
   localparam int unsigned MAG_W        = 8;
   localparam int unsigned SCORE_W      = 16;
   localparam int unsigned LFSR_W       = 9;
   localparam int unsigned PLAT_SPACING = 30;
   localparam int unsigned SCREEN_Y_MAX = 479;
   localparam int unsigned WRAP_H       = 480;
   localparam int unsigned X_BASE       = 64;
   localparam int unsigned LOAD_Y_TOP   = 464;

   localparam logic [LFSR_W-1:0] LFSR_SEED = 9'h1A5;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      SCROLL = 2'd2,
      ACK    = 2'd3
   } state_t;

   typedef struct packed {
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
   } plat_t;

   // New X position drawn from the low byte of the LFSR, offset from the left edge.
   function automatic logic [COORD_W-1:0] spawn_x(input logic [LFSR_W-1:0] lfsr);
      return COORD_W'(X_BASE) + COORD_W'(lfsr[MAG_W-1:0]);
   endfunction

   // Initial layout: platform 0 near the bottom, each next one PLAT_SPACING higher.
   function automatic logic [COORD_W-1:0] load_y(input logic [IDX_W-1:0] idx);
      return COORD_W'(LOAD_Y_TOP - PLAT_SPACING * 32'(idx));
   endfunction

endpackage

// File: rtl/platform_scroller_lfsr9.sv
// Free-running 9-bit Fibonacci LFSR (x^9 + x^5 + 1) used for platform X placement.
module lfsr9
   import platform_scroller_pkg::*;
(
   input  logic              Clk,
   input  logic              Reset,
   output logic [LFSR_W-1:0] q
);

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         q <= LFSR_SEED;
      end else begin
         q <= {q[LFSR_W-2:0], q[8] ^ q[4]};
      end
   end

endmodule

// File: rtl/platform_scroller.sv
// Platform layout and scroll engine: builds the initial platform column, then
// shifts every platform down by the doodle's upward motion, respawning at the top.
module platform_scroller
   import platform_scroller_pkg::*;
(
   input  logic               Clk,
   input  logic               Reset,
   input  logic               loadplat,
   input  logic               refresh_en,
   input  logic [MOT_W-1:0]   plat_temp_Y,
   output logic [COORD_W-1:0] platX0,
   output logic [COORD_W-1:0] platX1,
   output logic [COORD_W-1:0] platX2,
   output logic [COORD_W-1:0] platX3,
   output logic [COORD_W-1:0] platX4,
   output logic [COORD_W-1:0] platX5,
   output logic [COORD_W-1:0] platX6,
   output logic [COORD_W-1:0] platX7,
   output logic [COORD_W-1:0] platX8,
   output logic [COORD_W-1:0] platX9,
   output logic [COORD_W-1:0] platX10,
   output logic [COORD_W-1:0] platX11,
   output logic [COORD_W-1:0] platX12,
   output logic [COORD_W-1:0] platX13,
   output logic [COORD_W-1:0] platX14,
   output logic [COORD_W-1:0] platX15,
   output logic [COORD_W-1:0] platY0,
   output logic [COORD_W-1:0] platY1,
   output logic [COORD_W-1:0] platY2,
   output logic [COORD_W-1:0] platY3,
   output logic [COORD_W-1:0] platY4,
   output logic [COORD_W-1:0] platY5,
   output logic [COORD_W-1:0] platY6,
   output logic [COORD_W-1:0] platY7,
   output logic [COORD_W-1:0] platY8,
   output logic [COORD_W-1:0] platY9,
   output logic [COORD_W-1:0] platY10,
   output logic [COORD_W-1:0] platY11,
   output logic [COORD_W-1:0] platY12,
   output logic [COORD_W-1:0] platY13,
   output logic [COORD_W-1:0] platY14,
   output logic [COORD_W-1:0] platY15,
   output logic               trigger,
   output logic               busy,
   output logic [SCORE_W-1:0] score
);

   state_t               state_q, state_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [MAG_W-1:0]     mag_q, mag_d;
   logic [SCORE_W-1:0]   score_d;
   logic                 trigger_d, busy_d;
   plat_t                plat_q [NUM_PLAT];
   plat_t                plat_d [NUM_PLAT];
   logic [LFSR_W-1:0]    lfsr;
   logic [MOT_W-1:0]     new_y;
   logic [MOT_W-1:0]     neg_motion;
   logic                 last_idx;

   lfsr9 u_lfsr (
      .Clk   (Clk),
      .Reset (Reset),
      .q     (lfsr)
   );

   // State and datapath registers
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         mag_q   <= '0;
         score   <= '0;
         trigger <= 1'b0;
         busy    <= 1'b0;
         plat_q  <= '{default: '0};
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         mag_q   <= mag_d;
         score   <= score_d;
         trigger <= trigger_d;
         busy    <= busy_d;
         plat_q  <= plat_d;
      end
   end

   // Next-state, platform update and registered-output decode
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      mag_d      = mag_q;
      score_d    = score;
      trigger_d  = 1'b0;
      busy_d     = 1'b0;
      plat_d     = plat_q;
      neg_motion = -plat_temp_Y;
      new_y      = MOT_W'(plat_q[idx_q].y) + MOT_W'(mag_q);
      last_idx   = (idx_q == IDX_W'(NUM_PLAT - 1));

      case (state_q)
         IDLE: begin
            if (loadplat) begin
               idx_d   = '0;
               state_d = LOAD;
            end else if (refresh_en) begin
               // Only upward motion (negative Y) scrolls the screen.
               mag_d   = plat_temp_Y[MOT_W-1] ? neg_motion[MAG_W-1:0] : '0;
               idx_d   = '0;
               state_d = SCROLL;
            end
         end

         LOAD: begin
            plat_d[idx_q].x = spawn_x(lfsr);
            plat_d[idx_q].y = load_y(idx_q);
            idx_d           = idx_q + IDX_W'(1);
            if (last_idx) begin
               score_d = '0;
               state_d = IDLE;
            end
         end

         SCROLL: begin
            if (new_y > MOT_W'(SCREEN_Y_MAX)) begin
               plat_d[idx_q].y = COORD_W'(new_y - MOT_W'(WRAP_H));
               plat_d[idx_q].x = spawn_x(lfsr);
            end else begin
               plat_d[idx_q].y = COORD_W'(new_y);
            end
            idx_d = idx_q + IDX_W'(1);
            if (last_idx) begin
               score_d = score + SCORE_W'(mag_q);
               state_d = ACK;
            end
         end

         ACK: begin
            if (refresh_en) begin
               trigger_d = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase

      busy_d = (state_d == LOAD) || (state_d == SCROLL);
   end

   assign platX0  = plat_q[0].x;
   assign platX1  = plat_q[1].x;
   assign platX2  = plat_q[2].x;
   assign platX3  = plat_q[3].x;
   assign platX4  = plat_q[4].x;
   assign platX5  = plat_q[5].x;
   assign platX6  = plat_q[6].x;
   assign platX7  = plat_q[7].x;
   assign platX8  = plat_q[8].x;
   assign platX9  = plat_q[9].x;
   assign platX10 = plat_q[10].x;
   assign platX11 = plat_q[11].x;
   assign platX12 = plat_q[12].x;
   assign platX13 = plat_q[13].x;
   assign platX14 = plat_q[14].x;
   assign platX15 = plat_q[15].x;
   assign platY0  = plat_q[0].y;
   assign platY1  = plat_q[1].y;
   assign platY2  = plat_q[2].y;
   assign platY3  = plat_q[3].y;
   assign platY4  = plat_q[4].y;
   assign platY5  = plat_q[5].y;
   assign platY6  = plat_q[6].y;
   assign platY7  = plat_q[7].y;
   assign platY8  = plat_q[8].y;
   assign platY9  = plat_q[9].y;
   assign platY10 = plat_q[10].y;
   assign platY11 = plat_q[11].y;
   assign platY12 = plat_q[12].y;
   assign platY13 = plat_q[13].y;
   assign platY14 = plat_q[14].y;
   assign platY15 = plat_q[15].y;

endmodule

// File: tb/tb_platform_scroller.sv
// Self-checking bench for platform_scroller: directed load/scroll/handshake/reset
// sequences against a transaction-level model of the platform column.
module tb_platform_scroller;

   logic       Clk;
   logic       Reset;
   logic       loadplat;
   logic       refresh_en;
   logic [9:0] plat_temp_Y;
   logic [8:0] px [16];
   logic [8:0] py [16];
   logic       trigger;
   logic       busy;
   logic [15:0] score;

   int n_checks = 0;
   int n_fail   = 0;

   // Model state owned by the driver
   int  my [16];
   int  x_gen [16];
   bit  x_zero [16];
   int  exp_score;
   bit  exp_busy;
   bit  exp_trig;
   bit  check_en;

   // X snapshot owned by the compare process
   int  xs [16];
   int  xs_gen [16];

   platform_scroller dut (
      .Clk(Clk), .Reset(Reset), .loadplat(loadplat), .refresh_en(refresh_en),
      .plat_temp_Y(plat_temp_Y),
      .platX0(px[0]),   .platX1(px[1]),   .platX2(px[2]),   .platX3(px[3]),
      .platX4(px[4]),   .platX5(px[5]),   .platX6(px[6]),   .platX7(px[7]),
      .platX8(px[8]),   .platX9(px[9]),   .platX10(px[10]), .platX11(px[11]),
      .platX12(px[12]), .platX13(px[13]), .platX14(px[14]), .platX15(px[15]),
      .platY0(py[0]),   .platY1(py[1]),   .platY2(py[2]),   .platY3(py[3]),
      .platY4(py[4]),   .platY5(py[5]),   .platY6(py[6]),   .platY7(py[7]),
      .platY8(py[8]),   .platY9(py[9]),   .platY10(py[10]), .platY11(py[11]),
      .platY12(py[12]), .platY13(py[13]), .platY14(py[14]), .platY15(py[15]),
      .trigger(trigger), .busy(busy), .score(score)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Per-cycle compare against the model
   always @(negedge Clk) begin
      if (check_en) begin
         check("busy", int'(busy), int'(exp_busy));
         check("trigger", int'(trigger), int'(exp_trig));
         check("score", int'(score), exp_score);
         if (!exp_busy) begin
            for (int i = 0; i < 16; i++) begin
               check($sformatf("platY%0d", i), int'(py[i]), my[i]);
               if (x_zero[i]) begin
                  check($sformatf("platX%0d_zero", i), int'(px[i]), 0);
               end else if (xs_gen[i] != x_gen[i]) begin
                  check($sformatf("platX%0d_range", i),
                        int'(px[i] >= 9'd64 && px[i] <= 9'd319), 1);
                  xs[i]     = int'(px[i]);
                  xs_gen[i] = x_gen[i];
               end else begin
                  check($sformatf("platX%0d_hold", i), int'(px[i]), xs[i]);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   function automatic int mag_of(input logic [9:0] m);
      return m[9] ? ((1024 - int'(m)) % 256) : 0;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) begin
         my[i]     = 0;
         x_zero[i] = 1'b1;
      end
      exp_score = 0;
      exp_busy  = 1'b0;
      exp_trig  = 1'b0;
   endtask

   task automatic model_load();
      for (int i = 0; i < 16; i++) begin
         my[i]     = 464 - 30 * i;
         x_zero[i] = 1'b0;
         x_gen[i]  = x_gen[i] + 1;
      end
      exp_score = 0;
   endtask

   task automatic model_scroll(input int mag);
      for (int i = 0; i < 16; i++) begin
         if (my[i] + mag > 479) begin
            my[i]    = my[i] + mag - 480;
            x_gen[i] = x_gen[i] + 1;
         end else begin
            my[i] = my[i] + mag;
         end
      end
      exp_score = (exp_score + mag) % 65536;
   endtask

   // Load; with also_refresh the scroll request arrives on the same cycle
   task automatic do_load(input bit also_refresh);
      loadplat   = 1'b1;
      refresh_en = also_refresh;
      tick();
      loadplat   = 1'b0;
      refresh_en = 1'b0;
      exp_busy   = 1'b1;
      repeat (15) tick();
      tick();
      exp_busy = 1'b0;
      model_load();
   endtask

   // Scroll request, held for hold cycles past trigger; meddle disturbs inputs mid-scroll
   task automatic do_scroll(input logic [9:0] mot, input int hold, input bit meddle);
      int mag;
      mag         = mag_of(mot);
      plat_temp_Y = mot;
      refresh_en  = 1'b1;
      tick();
      exp_busy = 1'b1;
      for (int k = 1; k <= 15; k++) begin
         if (meddle && k == 5) begin
            loadplat    = 1'b1;
            plat_temp_Y = 10'h3C0;
         end
         if (k == 6) loadplat = 1'b0;
         tick();
      end
      tick();
      exp_busy = 1'b0;
      model_scroll(mag);
      check("trigger_at_16", int'(trigger), 0);
      tick();
      exp_trig = 1'b1;
      check("trigger_at_17", int'(trigger), 1);
      repeat (hold) tick();
      check("trigger_held", int'(trigger), 1);
      refresh_en = 1'b0;
      tick();
      exp_trig = 1'b0;
      check("trigger_drop", int'(trigger), 0);
      check("busy_after_ack", int'(busy), 0);
      plat_temp_Y = 10'h000;
   endtask

   initial begin
      int distinct;
      for (int i = 0; i < 16; i++) begin
         x_gen[i] = 0;
         xs_gen[i] = 0;
         xs[i] = 0;
      end
      Reset       = 1'b1;
      loadplat    = 1'b0;
      refresh_en  = 1'b0;
      plat_temp_Y = 10'h000;
      model_reset();
      check_en = 1'b1;
      repeat (3) tick();
      check("rst_busy", int'(busy), 0);
      check("rst_platY0", int'(py[0]), 0);
      check("rst_platX15", int'(px[15]), 0);
      Reset = 1'b0;
      tick();

      do_load(1'b0);
      tick();
      check("load_platY0", int'(py[0]), 464);
      check("load_platY15", int'(py[15]), 14);
      check("load_score", int'(score), 0);
      distinct = 0;
      for (int i = 1; i < 16; i++) if (px[i] != px[0]) distinct++;
      check("load_x_varies", int'(distinct > 0), 1);

      do_scroll(10'h3F6, 0, 1'b0);
      check("s1_platY0", int'(py[0]), 474);
      check("s1_platY15", int'(py[15]), 24);
      check("s1_score", int'(score), 10);

      do_scroll(10'h3F6, 5, 1'b1);
      check("s2_platY0", int'(py[0]), 4);
      check("s2_platY15", int'(py[15]), 34);
      check("s2_score", int'(score), 20);

      do_scroll(10'h005, 0, 1'b0);
      check("s3_platY0", int'(py[0]), 4);
      check("s3_score", int'(score), 20);

      do_load(1'b1);
      tick();
      check("prio_platY0", int'(py[0]), 464);
      check("prio_score", int'(score), 0);

      do_scroll(10'h301, 1, 1'b0);
      check("s4_platY0", int'(py[0]), 239);
      check("s4_platY1", int'(py[1]), 209);
      check("s4_score", int'(score), 255);

      // Reset while the scroll engine is at platform 7
      plat_temp_Y = 10'h3F6;
      refresh_en  = 1'b1;
      tick();
      exp_busy = 1'b1;
      repeat (7) tick();
      Reset      = 1'b1;
      refresh_en = 1'b0;
      model_reset();
      #1;
      check("mid_rst_busy", int'(busy), 0);
      check("mid_rst_trigger", int'(trigger), 0);
      check("mid_rst_score", int'(score), 0);
      check("mid_rst_platY0", int'(py[0]), 0);
      check("mid_rst_platX3", int'(px[3]), 0);
      repeat (2) tick();
      Reset = 1'b0;
      repeat (4) tick();

      do_load(1'b0);
      tick();
      check("reload_platY0", int'(py[0]), 464);
      check("reload_platY15", int'(py[15]), 14);
      check("reload_score", int'(score), 0);
      repeat (2) tick();

      check_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
